fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/y86_pkg.sv | 61 ++++++
 rtl/y86_ilen.sv | 38 +++
 rtl/fetch_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the fetch sequencer: instruction codes, status
// codes, sequencer states and the decoded-field record.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPC,
    S_REG,
    S_CONST,
    S_DONE,
    S_STOP
  } state_t;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] instr_pc;
    stat_t       stat;
  } fields_t;

  // Field record at the start of a fetch: nothing decoded yet, status OK.
  function automatic fields_t blank_fields(input logic [63:0] pc);
    fields_t f;
    f.icode    = 4'h0;
    f.ifun     = 4'h0;
    f.ra       = RNONE;
    f.rb       = RNONE;
    f.valc     = 64'd0;
    f.valp     = 64'd0;
    f.instr_pc = pc;
    f.stat     = STAT_AOK;
    return f;
  endfunction

endpackage

// File: rtl/y86_ilen.sv
// Instruction-length decoder: maps an icode to its byte length and to which
// optional parts (register byte, 8-byte constant) follow the opcode byte.
module y86_ilen
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] length,
  output logic       has_reg,
  output logic       has_const,
  output logic       valid
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    length    = 4'd0;
    has_reg   = 1'b0;
    has_const = 1'b0;
    valid     = 1'b1;
    case (icode)
      I_HALT, I_NOP, I_RET: length = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
        length  = 4'd2;
        has_reg = 1'b1;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        length    = 4'd10;
        has_reg   = 1'b1;
        has_const = 1'b1;
      end
      I_JXX, I_CALL: begin
        length    = 4'd9;
        has_const = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Byte-serial Y86-64 fetch sequencer: reads one instruction byte per memory
// handshake, assembles the decoded fields and presents them with valid/ready.
module fetch_sequencer
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] instr_pc,
  output logic [2:0]  stat
);

  state_t      state;
  logic [63:0] pc;
  logic [2:0]  k;
  fields_t     f;

  logic [3:0]  ilen_icode;
  logic [3:0]  len;
  logic        has_reg;
  logic        has_const;
  logic        icode_ok;

  // The opcode byte is decoded straight off the bus; later states use the latched icode.
  assign ilen_icode = (state == S_OPC) ? mem_rdata[7:4] : f.icode;

  y86_ilen u_ilen (
    .icode     (ilen_icode),
    .length    (len),
    .has_reg   (has_reg),
    .has_const (has_const),
    .valid     (icode_ok)
  );

  assign icode    = f.icode;
  assign ifun     = f.ifun;
  assign rA       = f.ra;
  assign rB       = f.rb;
  assign valC     = f.valc;
  assign valP     = f.valp;
  assign instr_pc = f.instr_pc;
  assign stat     = f.stat;

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= 64'd0;
      k         <= 3'd0;
      mem_req   <= 1'b0;
      mem_addr  <= 64'd0;
      out_valid <= 1'b0;
      f         <= blank_fields(64'd0);
    end else if (redirect_valid) begin
      // Redirect wins over any coincident ack or accept in every state.
      state     <= S_OPC;
      pc        <= redirect_pc;
      k         <= 3'd0;
      mem_req   <= 1'b1;
      mem_addr  <= redirect_pc;
      out_valid <= 1'b0;
      f         <= blank_fields(redirect_pc);
    end else begin
      case (state)
        S_IDLE, S_STOP: begin
          mem_req   <= 1'b0;
          out_valid <= 1'b0;
        end

        S_OPC: begin
          if (mem_ack) begin
            mem_addr <= mem_addr + 64'd1;
            if (mem_err) begin
              f.stat    <= STAT_ADR;
              state     <= S_DONE;
              mem_req   <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              f.icode <= mem_rdata[7:4];
              f.ifun  <= mem_rdata[3:0];
              f.valp  <= (mem_rdata[7:4] == I_HALT) ? pc : pc + {60'd0, len};
              if (!icode_ok || mem_rdata[7:4] == I_HALT) begin
                f.stat    <= icode_ok ? STAT_HLT : STAT_INS;
                state     <= S_DONE;
                mem_req   <= 1'b0;
                out_valid <= 1'b1;
              end else if (has_reg) begin
                state <= S_REG;
              end else if (has_const) begin
                state <= S_CONST;
                k     <= 3'd0;
              end else begin
                state     <= S_DONE;
                mem_req   <= 1'b0;
                out_valid <= 1'b1;
              end
            end
          end
        end

        S_REG: begin
          if (mem_ack) begin
            mem_addr <= mem_addr + 64'd1;
            if (mem_err) begin
              f.stat    <= STAT_ADR;
              state     <= S_DONE;
              mem_req   <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              f.ra <= mem_rdata[7:4];
              f.rb <= mem_rdata[3:0];
              if (has_const) begin
                state <= S_CONST;
                k     <= 3'd0;
              end else begin
                state     <= S_DONE;
                mem_req   <= 1'b0;
                out_valid <= 1'b1;
              end
            end
          end
        end

        S_CONST: begin
          if (mem_ack) begin
            mem_addr <= mem_addr + 64'd1;
            if (mem_err) begin
              f.stat    <= STAT_ADR;
              state     <= S_DONE;
              k         <= 3'd0;
              mem_req   <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              // Little-endian: byte k lands in bits [8k+7:8k].
              f.valc[{k, 3'b000} +: 8] <= mem_rdata;
              if (k == 3'd7) begin
                state     <= S_DONE;
                k         <= 3'd0;
                mem_req   <= 1'b0;
                out_valid <= 1'b1;
              end else begin
                k <= k + 3'd1;
              end
            end
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (f.stat == STAT_AOK) begin
              state    <= S_OPC;
              pc       <= f.valp;
              mem_req  <= 1'b1;
              mem_addr <= f.valp;
              f        <= blank_fields(f.valp);
            end else begin
              state   <= S_STOP;
              mem_req <= 1'b0;
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          mem_req   <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a byte-memory responder with optional
// random ack delay, directed programs, and a monitor that checks each accepted output.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        mem_err;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valc, valp, ipc;
  logic [2:0]  stat;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .mem_err        (mem_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .icode          (icode),
    .ifun           (ifun),
    .rA             (ra),
    .rB             (rb),
    .valC           (valc),
    .valP           (valp),
    .instr_pc       (ipc),
    .stat           (stat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, ipc;
    logic [2:0]  stat;
    bit          chk_valp;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem     [logic [63:0]];
  bit          err_at  [logic [63:0]];
  bit          req_seen[logic [63:0]];
  int          ack_count = 0;
  int          max_delay = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                      input logic [3:0] b, input logic [63:0] c, input logic [63:0] p,
                      input logic [63:0] pc, input logic [2:0] st, input bit cp);
    exp_t e;
    e.icode = ic; e.ifun = fn; e.ra = a; e.rb = b;
    e.valc = c; e.valp = p; e.ipc = pc; e.stat = st; e.chk_valp = cp;
    sb.push_back(e);
  endtask

  task automatic poke(input logic [63:0] a, input logic [7:0] b);
    mem[a] = b;
  endtask

  task automatic poke_word(input logic [63:0] a, input logic [63:0] w);
    for (int i = 0; i < 8; i++) mem[a + 64'(i)] = w[8*i +: 8];
  endtask

  // Inputs change 2 time units after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n = 0;
    while (ack_count < target && n < budget) begin
      tick();
      n++;
    end
    check("ack_wait", 64'(ack_count), 64'(target));
  endtask

  task automatic expect_quiet(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check("quiet_mem_req", 64'(mem_req), 64'd0);
      check("quiet_out_valid", 64'(out_valid), 64'd0);
    end
  endtask

  task automatic check_reset_values();
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_icode", 64'(icode), 64'd0);
    check("rst_ifun", 64'(ifun), 64'd0);
    check("rst_rA", 64'(ra), 64'hF);
    check("rst_rB", 64'(rb), 64'hF);
    check("rst_valC", valc, 64'd0);
    check("rst_valP", valp, 64'd0);
    check("rst_instr_pc", ipc, 64'd0);
    check("rst_stat", 64'(stat), 64'd1);
  endtask

  // Memory responder: acks after 0..max_delay idle cycles, checks request stability.
  initial begin
    bit          prev_req = 1'b0;
    logic [63:0] prev_addr = 64'd0;
    int          wait_cnt = 0;
    mem_ack = 1'b0; mem_rdata = 8'h00; mem_err = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_req && !mem_ack && !redirect_valid && !rst) begin
        check("req_held", 64'(mem_req), 64'd1);
        check("addr_held", mem_addr, prev_addr);
      end
      mem_ack = 1'b0;
      mem_err = 1'b0;
      if (mem_req && !rst) begin
        req_seen[mem_addr] = 1'b1;
        if (wait_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
          mem_err   = err_at.exists(mem_addr);
          ack_count++;
          wait_cnt  = $urandom_range(max_delay, 0);
        end else begin
          wait_cnt--;
        end
      end
      prev_req  = mem_req && !rst;
      prev_addr = mem_addr;
    end
  end

  // Monitor: compares every accepted output against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready && !redirect_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_output_pc", ipc, ~ipc);
        end else begin
          e = sb.pop_front();
          check("icode", 64'(icode), 64'(e.icode));
          check("ifun", 64'(ifun), 64'(e.ifun));
          check("rA", 64'(ra), 64'(e.ra));
          check("rB", 64'(rb), 64'(e.rb));
          check("valC", valc, e.valc);
          if (e.chk_valp) check("valP", valp, e.valp);
          check("instr_pc", ipc, e.ipc);
          check("stat", 64'(stat), 64'(e.stat));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'd0; out_ready = 1'b1;

    poke(64'h100, 8'h30); poke(64'h101, 8'hF3);
    poke_word(64'h102, 64'h0102030405060708); poke(64'h10A, 8'h00);
    poke(64'h200, 8'h60); poke(64'h201, 8'h01); poke(64'h202, 8'h70);
    poke_word(64'h203, 64'h200); poke(64'h20B, 8'h00);
    poke(64'h300, 8'hC0);
    poke(64'h400, 8'h30); poke(64'h401, 8'hF5);
    poke_word(64'h402, 64'h8877665544332211); err_at[64'h404] = 1'b1;
    poke(64'h500, 8'h10); poke(64'h501, 8'h00);
    poke(64'hFFFF_FFFF_FFFF_FFFF, 8'h10); poke(64'h0, 8'h00);

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset_values();
    expect_quiet(3);

    // irmovq then halt, zero-delay memory
    push(4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 64'h10A, 64'h100, 3'd1, 1);
    push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h10A, 64'h10A, 3'd2, 1);
    redirect(64'h100);
    wait_drain(100);
    expect_quiet(4);

    // opq / jxx / halt sequence
    push(4'h6, 4'h0, 4'h0, 4'h1, 64'd0, 64'h202, 64'h200, 3'd1, 1);
    push(4'h7, 4'h0, 4'hF, 4'hF, 64'h200, 64'h20B, 64'h202, 3'd1, 1);
    push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h20B, 64'h20B, 3'd2, 1);
    redirect(64'h200);
    wait_drain(100);
    expect_quiet(4);

    // invalid opcode: one read, then STOP; redirect restarts
    base = ack_count;
    push(4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'h300, 3'd4, 0);
    redirect(64'h300);
    wait_drain(50);
    expect_quiet(3);
    check("ins_read_count", 64'(ack_count - base), 64'd1);
    push(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h501, 64'h500, 3'd1, 1);
    push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h501, 64'h501, 3'd2, 1);
    redirect(64'h500);
    wait_drain(50);

    // pc wrap-around: nop at the top of the address space
    push(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1);
    push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'd0, 3'd2, 1);
    redirect(64'hFFFF_FFFF_FFFF_FFFF);
    wait_drain(50);

    // address error on the 5th byte under random ack delay
    max_delay = 5;
    base = ack_count;
    push(4'h3, 4'h0, 4'hF, 4'h5, 64'h2211, 64'd0, 64'h400, 3'd3, 0);
    redirect(64'h400);
    wait_drain(200);
    expect_quiet(3);
    check("adr_read_count", 64'(ack_count - base), 64'd5);
    check("adr_no_6th_request", 64'(req_seen.exists(64'h405)), 64'd0);

    // same irmovq under random delay decodes identically
    push(4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 64'h10A, 64'h100, 3'd1, 1);
    push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h10A, 64'h10A, 3'd2, 1);
    redirect(64'h100);
    wait_drain(300);
    max_delay = 0;

    // redirect in the middle of the constant (k=3)
    base = ack_count;
    redirect(64'h100);
    wait_acks(base + 5, 50);
    push(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h501, 64'h500, 3'd1, 1);
    push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h501, 64'h501, 3'd2, 1);
    redirect(64'h500);
    wait_drain(50);

    // redirect while an output is held unaccepted
    out_ready = 1'b0;
    redirect(64'h100);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
    end
    check("held_valid_wait", 64'(out_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_valid", 64'(out_valid), 64'd1);
      check("held_valC", valc, 64'h0102030405060708);
      check("held_valP", valp, 64'h10A);
    end
    push(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h501, 64'h500, 3'd1, 1);
    push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h501, 64'h501, 3'd2, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h500;
    out_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("valid_drop_after_redirect", 64'(out_valid), 64'd0);
    wait_drain(50);

    // asynchronous reset at k=5
    base = ack_count;
    redirect(64'h100);
    wait_acks(base + 7, 50);
    rst = 1'b1;
    #1;
    check_reset_values();
    tick();
    rst = 1'b0;
    expect_quiet(3);
    check("scoreboard_empty_end", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
